// File: rtl/ena_seq_if.sv
// Handshake and scoreboard signals between ena_sequencer (master) and the
// counter harness (slave) it drives and checks.
interface ena_seq_if #(
  parameter int WIDTH = 4,
  parameter int GAP_W = 4
);
  logic             start;
  logic [WIDTH-1:0] burst_len;
  logic [GAP_W-1:0] gap;
  logic [WIDTH-1:0] count_in;
  logic             ena;
  logic             busy;
  logic             done;
  logic             mismatch;
  logic [WIDTH-1:0] exp_count;
  logic             limit_ok;

  modport master (
    input  start, burst_len, gap, count_in,
    output ena, busy, done, mismatch, exp_count, limit_ok
  );

  modport slave (
    output start, burst_len, gap, count_in,
    input  ena, busy, done, mismatch, exp_count, limit_ok
  );
endinterface

// File: rtl/ena_sequencer.sv
// Issues a programmed burst of ena pulses to an up-counter and scoreboards the
// returned count. Optional limit check enabled by ENA_SEQ_LIMIT_CHECK_EN.
module ena_sequencer #(
  parameter int WIDTH = 4,
  parameter int GAP_W = 4,
  parameter int LIMIT = 5
) (
  input logic      clk,
  input logic      rst,
  ena_seq_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PULSE,
    S_GAP,
    S_CHECK,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [GAP_W-1:0] gap_r_q, gap_r_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             mismatch_q, mismatch_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      exp_q      <= '0;
      rem_q      <= '0;
      gap_r_q    <= '0;
      gap_cnt_q  <= '0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      rem_q      <= rem_d;
      gap_r_q    <= gap_r_d;
      gap_cnt_q  <= gap_cnt_d;
      mismatch_q <= mismatch_d;
    end
  end

  // NOTE: every next-state variable is defaulted to its held value first, so
  // no path through the case statement can leave one unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    rem_d      = rem_q;
    gap_r_d    = gap_r_q;
    gap_cnt_d  = gap_cnt_q;
    mismatch_d = mismatch_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          exp_d      = bus.count_in;
          rem_d      = bus.burst_len;
          gap_r_d    = bus.gap;
          mismatch_d = 1'b0;
          state_d    = (bus.burst_len == '0) ? S_DONE : S_PULSE;
        end
      end
      S_PULSE: begin
        exp_d = exp_q + WIDTH'(1);
        rem_d = rem_q - WIDTH'(1);
        if (rem_q == WIDTH'(1)) begin
          state_d = S_CHECK;
        end else if (gap_r_q == '0) begin
          state_d = S_PULSE;
        end else begin
          gap_cnt_d = gap_r_q;
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q - GAP_W'(1);
        if (gap_cnt_q == GAP_W'(1)) state_d = S_PULSE;
      end
      S_CHECK: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // The counter registers ena, so count_in tracks exp_q cycle for cycle.
    if ((state_q inside {S_PULSE, S_GAP, S_CHECK}) && (bus.count_in != exp_q)) begin
      mismatch_d = 1'b1;
    end
  end

  assign bus.ena       = (state_q == S_PULSE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.mismatch  = mismatch_q;
  assign bus.exp_count = exp_q;

`ifdef ENA_SEQ_LIMIT_CHECK_EN
  logic ena_dly_q;

  always_ff @(posedge clk) begin
    if (rst) ena_dly_q <= 1'b0;
    else     ena_dly_q <= (state_q == S_PULSE);
  end

  assign bus.limit_ok = !(ena_dly_q && (int'(bus.count_in) >= LIMIT));
`else
  assign bus.limit_ok = 1'b1;
`endif

endmodule
